switch_cfg_loader: RTL



---
 rtl/switch_cfg_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/switch_cfg_loader.sv
// Serial loader for switch-matrix routing selects: sync hunt, shadow load, atomic commit.
// Optional CRC-8 trailer check is enabled by defining CFG_CRC_CHECK_EN.
module switch_cfg_loader #(
    parameter int unsigned N_TB  = 5,
    parameter int unsigned N_LR  = 4,
    parameter int unsigned ENT_W = 6,
    parameter logic [7:0]  SYNC  = 8'hA5,
    localparam int unsigned NENT = 2*N_TB + 2*N_LR,
    localparam int unsigned CW   = ENT_W*NENT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    input  logic          cfg_din,
    input  logic          cfg_abort,
    output logic [CW-1:0] cfg_out,
    output logic          cfg_commit,
    output logic          cfg_err,
    output logic          cfg_busy,
    output logic [7:0]    err_cnt
);

    localparam int unsigned BW = ($clog2(ENT_W) > 3) ? $clog2(ENT_W) : 3;
    localparam int unsigned EW = $clog2(NENT);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_LOAD = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    state_t           r_state, w_state;
    logic [7:0]       r_sr, w_sr;
    logic [BW-1:0]    r_bcnt, w_bcnt;
    logic [EW-1:0]    r_ecnt, w_ecnt;
    logic [ENT_W-2:0] r_acc, w_acc;
    logic [CW-1:0]    r_shadow, w_shadow;
    logic [CW-1:0]    r_out, w_out;
    logic             r_commit, w_commit;
    logic             r_busy, w_busy;
    logic [ENT_W-1:0] w_ent;

`ifdef CFG_CRC_CHECK_EN
    logic [7:0] r_crc, w_crc;
    logic [7:0] r_trl, w_trl;
    logic       r_err, w_err;
    logic [7:0] r_errcnt, w_errcnt;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
        logic fb;
        fb = c[7] ^ d;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // Entries arrive MSB-first; each completed entry is pushed in from the top
    // so entry 0 ends up at the bottom of the word.
    assign w_ent = {r_acc, cfg_din};

    always_comb begin
        w_state  = r_state;
        w_sr     = r_sr;
        w_bcnt   = r_bcnt;
        w_ecnt   = r_ecnt;
        w_acc    = r_acc;
        w_shadow = r_shadow;
        w_out    = r_out;
        w_commit = 1'b0;
`ifdef CFG_CRC_CHECK_EN
        w_crc    = r_crc;
        w_trl    = r_trl;
        w_err    = 1'b0;
        w_errcnt = r_errcnt;
`endif
        if (cfg_abort) begin
            w_state = S_HUNT;
            w_sr    = '0;
            w_bcnt  = '0;
            w_ecnt  = '0;
`ifdef CFG_CRC_CHECK_EN
            w_crc   = '0;
`endif
        end else if (cfg_valid) begin
            unique case (r_state)
                S_HUNT: begin
                    w_sr = {r_sr[6:0], cfg_din};
                    if (w_sr == SYNC) begin
                        w_state = S_LOAD;
                        w_bcnt  = '0;
                        w_ecnt  = '0;
`ifdef CFG_CRC_CHECK_EN
                        w_crc   = '0;
`endif
                    end
                end
                S_LOAD: begin
                    w_acc  = w_ent[ENT_W-2:0];
                    w_bcnt = r_bcnt + 1'b1;
`ifdef CFG_CRC_CHECK_EN
                    w_crc  = crc_step(r_crc, cfg_din);
`endif
                    if (r_bcnt == BW'(ENT_W-1)) begin
                        w_bcnt   = '0;
                        w_ecnt   = r_ecnt + 1'b1;
                        w_shadow = {w_ent, r_shadow[CW-1:ENT_W]};
                        if (r_ecnt == EW'(NENT-1)) begin
                            w_ecnt = '0;
`ifdef CFG_CRC_CHECK_EN
                            w_state = S_CRC;
`else
                            w_out    = w_shadow;
                            w_commit = 1'b1;
                            w_state  = S_HUNT;
                            w_sr     = '0;
`endif
                        end
                    end
                end
`ifdef CFG_CRC_CHECK_EN
                S_CRC: begin
                    w_trl  = {r_trl[6:0], cfg_din};
                    w_bcnt = r_bcnt + 1'b1;
                    if (r_bcnt == BW'(7)) begin
                        w_bcnt  = '0;
                        w_state = S_HUNT;
                        w_sr    = '0;
                        if (w_trl == r_crc) begin
                            w_out    = r_shadow;
                            w_commit = 1'b1;
                        end else begin
                            w_err = 1'b1;
                            if (r_errcnt != 8'hFF)
                                w_errcnt = r_errcnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    w_state = S_HUNT;
                    w_sr    = '0;
                end
            endcase
        end
        w_busy = (w_state != S_HUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_HUNT;
            r_sr     <= '0;
            r_bcnt   <= '0;
            r_ecnt   <= '0;
            r_acc    <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_commit <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_sr     <= w_sr;
            r_bcnt   <= w_bcnt;
            r_ecnt   <= w_ecnt;
            r_acc    <= w_acc;
            r_shadow <= w_shadow;
            r_out    <= w_out;
            r_commit <= w_commit;
            r_busy   <= w_busy;
        end
    end

`ifdef CFG_CRC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc    <= '0;
            r_trl    <= '0;
            r_err    <= 1'b0;
            r_errcnt <= '0;
        end else begin
            r_crc    <= w_crc;
            r_trl    <= w_trl;
            r_err    <= w_err;
            r_errcnt <= w_errcnt;
        end
    end

    assign cfg_err = r_err;
    assign err_cnt = r_errcnt;
`else
    assign cfg_err = 1'b0;
    assign err_cnt = '0;
`endif

    assign cfg_out    = r_out;
    assign cfg_commit = r_commit;
    assign cfg_busy   = r_busy;

endmodule
